// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP widths, unpacked operand type and unpack helpers
package fp_pkg;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int GRS_W = 3;
   localparam int ADD_W = 1 + 1 + MAN_W + GRS_W;
   localparam int OP_W  = 1 + EXP_W + MAN_W;
   localparam int BIAS  = 127;
   localparam int SH_W  = $clog2(ADD_W);

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic             hidden;
      logic [MAN_W-1:0] frac;
   } fp_op_t;

   function automatic fp_op_t fp_unpack(input logic [OP_W-1:0] v);
      fp_op_t op;
      op.sign   = v[OP_W-1];
      op.exp    = v[OP_W-2:MAN_W];
      op.frac   = v[MAN_W-1:0];
      op.hidden = |op.exp;
      return op;
   endfunction

   // Denormals share the exponent of the smallest normal.
   function automatic logic [EXP_W-1:0] eff_exp(input fp_op_t op);
      return op.hidden ? op.exp : EXP_W'(1);
   endfunction

   function automatic logic is_special(input fp_op_t op);
      return &op.exp;
   endfunction

   function automatic logic is_zero(input fp_op_t op);
      return ~|op.exp & ~|op.frac;
   endfunction

   function automatic logic [ADD_W-1:0] addend(input fp_op_t op);
      return {1'b0, op.hidden, op.frac, {GRS_W{1'b0}}};
   endfunction

endpackage

// File: rtl/fp_sticky_shifter.sv
// rtl/fp_sticky_shifter.sv - right shift with sticky OR of lost bits, clamped amount
module fp_sticky_shifter
   import fp_pkg::*;
(
   input  logic [ADD_W-1:0] data_i,
   input  logic [EXP_W-1:0] shamt_i,
   output logic [ADD_W-1:0] data_o
);

   localparam logic [EXP_W-1:0] CLAMP = EXP_W'(ADD_W - 1);

   logic [SH_W-1:0]  sh;
   logic [ADD_W-1:0] lost_mask;
   logic             sticky;

   always_comb begin
      sh        = shamt_i[SH_W-1:0];
      lost_mask = ~({ADD_W{1'b1}} << sh);
      sticky    = |(data_i & lost_mask);
      // Beyond ADD_W-1 every bit lands in the sticky position.
      if (shamt_i >= CLAMP) begin
         data_o = {{(ADD_W-1){1'b0}}, |data_i};
      end else begin
         data_o = (data_i >> sh) | {{(ADD_W-1){1'b0}}, sticky};
      end
   end

endmodule

// File: rtl/fp_align_stage.sv
// rtl/fp_align_stage.sv - two-stage operand order/align pipeline feeding the CLA adder
module fp_align_stage
   import fp_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_a,
   input  logic [OP_W-1:0]  in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ADD_W-1:0] out_mant_l,
   output logic [ADD_W-1:0] out_mant_s,
   output logic             out_cin,
   output logic             out_eff_sub,
   output logic             out_sign,
   output logic [EXP_W-1:0] out_exp,
   output logic             out_special
);

   logic             s1_valid_q, s2_valid_q;
   logic             s1_adv, s2_adv;

   fp_op_t           op_a, op_b;
   fp_op_t           s1_l_d, s1_s_d, s1_l_q, s1_s_q;
   logic [EXP_W-1:0] s1_dist_d, s1_dist_q;
   logic             s1_eff_sub_d, s1_eff_sub_q;
   logic             s1_special_d, s1_special_q;

   logic [ADD_W-1:0] ms_shifted;
   logic [ADD_W-1:0] mant_l_d, mant_s_d, mant_l_q, mant_s_q;
   logic             eff_sub_q, sign_q, special_q;
   logic [EXP_W-1:0] exp_q;

   assign s2_adv   = ~s2_valid_q | out_ready;
   assign s1_adv   = ~s1_valid_q | s2_adv;
   assign in_ready = s1_adv;

   always_comb begin
      op_a = fp_unpack(in_a);
      op_b = fp_unpack(in_b);
      // Ties keep A as the larger so the result sign follows A.
      if ({op_a.exp, op_a.frac} >= {op_b.exp, op_b.frac}) begin
         s1_l_d = op_a;
         s1_s_d = op_b;
      end else begin
         s1_l_d = op_b;
         s1_s_d = op_a;
      end
      s1_dist_d    = eff_exp(s1_l_d) - eff_exp(s1_s_d);
      s1_eff_sub_d = op_a.sign ^ op_b.sign;
      s1_special_d = is_special(op_a) | is_special(op_b);
   end

   fp_sticky_shifter u_shifter (
      .data_i  (addend(s1_s_q)),
      .shamt_i (s1_dist_q),
      .data_o  (ms_shifted)
   );

   assign mant_l_d = addend(s1_l_q);
   assign mant_s_d = s1_eff_sub_q ? ~ms_shifted : ms_shifted;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_l_q       <= '0;
         s1_s_q       <= '0;
         s1_dist_q    <= '0;
         s1_eff_sub_q <= 1'b0;
         s1_special_q <= 1'b0;
         s2_valid_q   <= 1'b0;
         mant_l_q     <= '0;
         mant_s_q     <= '0;
         eff_sub_q    <= 1'b0;
         sign_q       <= 1'b0;
         exp_q        <= '0;
         special_q    <= 1'b0;
      end else begin
         if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
               s1_l_q       <= s1_l_d;
               s1_s_q       <= s1_s_d;
               s1_dist_q    <= s1_dist_d;
               s1_eff_sub_q <= s1_eff_sub_d;
               s1_special_q <= s1_special_d;
            end
         end
         if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               mant_l_q  <= mant_l_d;
               mant_s_q  <= mant_s_d;
               eff_sub_q <= s1_eff_sub_q;
               sign_q    <= s1_l_q.sign;
               exp_q     <= s1_l_q.exp;
               special_q <= s1_special_q;
            end
         end
      end
   end

   assign out_valid   = s2_valid_q;
   assign out_mant_l  = mant_l_q;
   assign out_mant_s  = mant_s_q;
   assign out_cin     = eff_sub_q;
   assign out_eff_sub = eff_sub_q;
   assign out_sign    = sign_q;
   assign out_exp     = exp_q;
   assign out_special = special_q;

endmodule

// File: tb/tb_fp_align_stage.sv
// tb/tb_fp_align_stage.sv - directed vectors plus arithmetic reference model for fp_align_stage
module tb_fp_align_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a, in_b;
   logic        out_valid;
   logic        out_ready;
   logic [27:0] out_mant_l, out_mant_s;
   logic        out_cin, out_eff_sub, out_sign, out_special;
   logic [7:0]  out_exp;

   typedef struct packed {
      logic [27:0] ml;
      logic [27:0] ms;
      logic        cin;
      logic        eff_sub;
      logic        sign;
      logic [7:0]  e;
      logic        special;
   } exp_t;

   int   tests = 0;
   int   fails = 0;
   int   acc_cnt = 0;
   exp_t q[$];
   logic [27:0] last_l, last_s;
   logic        last_cin;

   fp_align_stage dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_mant_l  (out_mant_l),
      .out_mant_s  (out_mant_s),
      .out_cin     (out_cin),
      .out_eff_sub (out_eff_sub),
      .out_sign    (out_sign),
      .out_exp     (out_exp),
      .out_special (out_special)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   // Reference: plain integer arithmetic on the IEEE fields.
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
      exp_t r;
      logic [31:0] l, s;
      longint el, es, d, ml, ms, p, sh;
      if (a[30:0] >= b[30:0]) begin l = a; s = b; end
      else begin l = b; s = a; end
      el = (l[30:23] == 8'd0) ? 1 : longint'(l[30:23]);
      es = (s[30:23] == 8'd0) ? 1 : longint'(s[30:23]);
      ml = longint'(l[22:0]) * 8 + ((l[30:23] != 8'd0) ? 67108864 : 0);
      ms = longint'(s[22:0]) * 8 + ((s[30:23] != 8'd0) ? 67108864 : 0);
      d  = el - es;
      if (d >= 27) begin
         sh = (ms != 0) ? 1 : 0;
      end else begin
         p = 1;
         for (int i = 0; i < d; i++) p = p * 2;
         sh = ms / p;
         if (ms % p != 0) sh = sh | 1;
      end
      r.eff_sub = a[31] ^ b[31];
      r.cin     = r.eff_sub;
      r.ml      = ml[27:0];
      p         = r.eff_sub ? (268435455 - sh) : sh;
      r.ms      = p[27:0];
      r.sign    = l[31];
      r.e       = l[30:23];
      r.special = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         q.delete();
      end else begin
         if (out_valid) begin
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL spurious_out_valid: got out_valid=1 expected no pending pair");
            end else begin
               chk("model_mant_l", out_mant_l, q[0].ml);
               chk("model_mant_s", out_mant_s, q[0].ms);
               chk("model_cin", out_cin, q[0].cin);
               chk("model_eff_sub", out_eff_sub, q[0].eff_sub);
               chk("model_sign", out_sign, q[0].sign);
               chk("model_exp", out_exp, q[0].e);
               chk("model_special", out_special, q[0].special);
               if (out_ready) void'(q.pop_front());
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(model(in_a, in_b));
            acc_cnt++;
         end
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b);
      bit done = 1'b0;
      in_a = a;
      in_b = b;
      in_valid = 1'b1;
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            done = 1'b1;
         end
      end
      in_valid = 1'b0;
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: pair %h/%h got no in_ready expected acceptance", a, b);
      end
   endtask

   task automatic vec(input string nm, input logic [31:0] a, input logic [31:0] b,
                      input logic [27:0] el, input logic [27:0] es, input logic ecin,
                      input logic [7:0] eexp, input logic esign, input logic espc);
      bit seen = 1'b0;
      send(a, b);
      for (int t = 0; t < 10 && !seen; t++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
            chk({nm, "_mant_l"}, out_mant_l, el);
            chk({nm, "_mant_s"}, out_mant_s, es);
            chk({nm, "_cin"}, out_cin, ecin);
            chk({nm, "_exp"}, out_exp, eexp);
            chk({nm, "_sign"}, out_sign, esign);
            chk({nm, "_special"}, out_special, espc);
            last_l = out_mant_l;
            last_s = out_mant_s;
            last_cin = out_cin;
         end
      end
      if (!seen) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got no out_valid expected result within 10 cycles", nm);
      end
   endtask

   task automatic drain();
      for (int t = 0; t < 30 && q.size() > 0; t++) @(negedge clk);
      chk("drain_empty", q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected completion");
      $fatal(1);
   end

   initial begin
      int acc0;
      rst = 1'b1;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      out_ready = 1'b1;
      last_l = '0;
      last_s = '0;
      last_cin = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_mant_l", out_mant_l, 0);
      chk("rst_mant_s", out_mant_s, 0);
      chk("rst_exp", out_exp, 0);
      chk("rst_cin", out_cin, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      vec("one_plus_one",  32'h3F800000, 32'h3F800000, 28'h4000000, 28'h4000000, 0, 8'h7F, 0, 0);
      vec("one_plus_half", 32'h3F800000, 32'h3F000000, 28'h4000000, 28'h2000000, 0, 8'h7F, 0, 0);
      vec("one_minus_3q",  32'h3F800000, 32'hBF400000, 28'h4000000, 28'hCFFFFFF, 1, 8'h7F, 0, 0);
      chk("cla_sum", 28'(last_l + last_s + 28'(last_cin)), 28'h1000000);
      vec("swap_far",      32'h30800000, 32'h3F800000, 28'h4000000, 28'h0000001, 0, 8'h7F, 0, 0);
      vec("equal_mag_sub", 32'h3F800000, 32'hBF800000, 28'h4000000, 28'hBFFFFFF, 1, 8'h7F, 0, 0);
      vec("denorm_swap",   32'h00000001, 32'h00800000, 28'h4000000, 28'h0000008, 0, 8'h01, 0, 0);
      vec("sticky_d25",    32'h3F800000, 32'h33000001, 28'h4000000, 28'h0000003, 0, 8'h7F, 0, 0);
      vec("zero_sub_zero", 32'h00000000, 32'h80000000, 28'h0000000, 28'hFFFFFFF, 1, 8'h00, 0, 0);
      vec("inf_special",   32'h7F800000, 32'h3F800000, 28'h4000000, 28'h0000001, 0, 8'hFF, 0, 1);
      drain();

      // Backpressure: hold the output for 4 cycles while three pairs queue up.
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      acc0 = acc_cnt;
      fork
         begin
            send(32'h3F800000, 32'h3F000000);
            send(32'h40000000, 32'hBF800000);
            send(32'h3F800000, 32'h30800000);
         end
         begin
            repeat (4) @(negedge clk);
            chk("bp_accepted", acc_cnt - acc0, 2);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      // Reset with both stages full, then check clean restart latency.
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      send(32'h3F800000, 32'h3F800000);
      send(32'h3F800000, 32'hBF400000);
      rst = 1'b1;
      @(negedge clk);
      chk("pre_rst_out_valid", out_valid, 1);
      chk("pre_rst_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      in_a = 32'h3F800000;
      in_b = 32'h3F000000;
      in_valid = 1'b1;
      @(negedge clk);
      chk("post_rst_out_valid", out_valid, 0);
      chk("post_rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("lat_cycle1_out_valid", out_valid, 0);
      @(negedge clk);
      chk("lat_cycle2_out_valid", out_valid, 1);
      chk("lat_cycle2_mant_s", out_mant_s, 28'h2000000);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
